// File: rtl/lockpick_vault.sv
// Lockpick vault: streams two keys in, hashes their XOR with an iterative Feistel core and compares it with TARGET.
// Optional hint comparator enabled by defining LOCKPICK_HINT_EN.
`timescale 1ns/1ps
module lockpick_vault #(
   parameter int           KEY_BYTES    = 32,
   parameter int           ROUNDS       = 3,
   parameter int           MAX_ATTEMPTS = 3,
   parameter int           COOLDOWN     = 1024,
   parameter logic [255:0] TARGET       = 256'hCAFEBABE_12345678_DEADBEEF_FEEDFACE_C001D00D_BADC0DE5_BAADF00D_0BADBEEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic [1:0] status,
   output logic [3:0] attempts_left,
   output logic       busy,
   output logic [5:0] hint_count
);

   localparam int IDX_W = (KEY_BYTES > 32) ? $clog2(KEY_BYTES) : 5;
   localparam int RND_W = $clog2(ROUNDS + 1);
   localparam int CD_W  = $clog2(COOLDOWN + 1);

   localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_BYTES - 1);
   localparam logic [IDX_W-1:0] MSG_LAST = IDX_W'(31);
   localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);
   localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN - 1);
   localparam logic [3:0]       ATT_MAX  = 4'(MAX_ATTEMPTS);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_HASH, ST_COMPARE, ST_OUTPUT, ST_LOCKED
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [RND_W-1:0] r_rnd;
   logic [CD_W-1:0]  r_cool;
   logic [3:0]       r_att;
   logic [1:0]       r_status;
   logic [255:0]     r_x;
   logic [255:0]     w_round;
   logic [31:0]      w_msg_word;
   logic             w_match;
   logic [3:0]       w_att_dec;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // AES S-box built algebraically: GF(2^8) inverse as x^254, then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [255:0] feistel_round(input logic [255:0] s);
      logic [63:0] a, b, c, d, f, g;
      a = s[255:192];
      b = s[191:128];
      c = s[127:64];
      d = s[63:0];
      f = ((b ^ d) + (a | c)) ^ {c[31:0], d[31:0]};
      for (int i = 0; i < 8; i++) g[8*i +: 8] = {f[8*i+6 -: 7], f[8*i+7]};
      f = {g[50:0], g[63:51]};
      for (int i = 0; i < 8; i++) g[8*i +: 8] = sbox(f[8*i +: 8]);
      a = a ^ g;
      b = {b[30:0], b[63:31]};
      c = c + a;
      d = ~d ^ b;
      a = {a[47:0], a[63:48]};
      return {a, b, c, d};
   endfunction

   assign w_round    = feistel_round(r_x);
   assign w_match    = (r_x == TARGET);
   assign w_att_dec  = (r_att != 4'd0) ? (r_att - 4'd1) : 4'd0;
   assign w_msg_word = (r_status == 2'b10) ? 32'hFACEFACE :
                       (r_status == 2'b11) ? 32'hDEADDEAD : 32'hBAD0BAD0;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE:    if (start) w_state_nxt = ST_LOAD_A;
         ST_LOAD_A: begin
            in_ready = 1'b1;
            if (in_valid && r_idx == KEY_LAST) w_state_nxt = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid && r_idx == KEY_LAST) w_state_nxt = ST_HASH;
         end
         ST_HASH:    if (r_rnd == RND_LAST) w_state_nxt = ST_COMPARE;
         ST_COMPARE: w_state_nxt = ST_OUTPUT;
         ST_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready && r_idx == MSG_LAST) begin
               if (r_status == 2'b10)      w_state_nxt = ST_IDLE;
               else if (r_status == 2'b11) w_state_nxt = ST_LOCKED;
               else                        w_state_nxt = ST_LOAD_A;
            end
         end
         ST_LOCKED:  if (r_cool == CD_LAST) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_rnd    <= '0;
         r_cool   <= '0;
         r_att    <= ATT_MAX;
         r_status <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         // byte index restarts at every phase change
         if (w_state_nxt != r_state)
            r_idx <= '0;
         else if ((in_ready && in_valid) || (out_valid && out_ready))
            r_idx <= r_idx + IDX_W'(1);
         r_rnd  <= (r_state == ST_HASH) ? r_rnd + RND_W'(1) : '0;
         r_cool <= (r_state == ST_LOCKED) ? r_cool + CD_W'(1) : '0;
         if (r_state == ST_IDLE && start)
            r_status <= 2'b00;
         if (r_state == ST_COMPARE) begin
            if (w_match) begin
               r_status <= 2'b10;
            end else begin
               r_att    <= w_att_dec;
               r_status <= (w_att_dec == 4'd0) ? 2'b11 : 2'b01;
            end
         end
         if (r_state == ST_LOCKED && w_state_nxt == ST_IDLE) begin
            r_att    <= ATT_MAX;
            r_status <= 2'b00;
         end
      end
   end

   // Both keys fold straight into one 256-bit accumulator; XOR folding is order-free.
   always_ff @(posedge clk) begin
      case (r_state)
         ST_LOAD_A, ST_LOAD_B:
            if (in_valid) r_x[{r_idx[4:0], 3'b000} +: 8] <= r_x[{r_idx[4:0], 3'b000} +: 8] ^ in_data;
         ST_HASH:    r_x <= w_round;
         ST_COMPARE: r_x <= r_x;
         default:    r_x <= '0;
      endcase
   end

   assign out_data      = (r_state == ST_OUTPUT) ? w_msg_word[{r_idx[1:0], 3'b000} +: 8] : 8'h00;
   assign status        = r_status;
   assign attempts_left = r_att;
   assign busy          = (r_state != ST_IDLE);

`ifdef LOCKPICK_HINT_EN
   logic [5:0] r_hint;
   logic [5:0] w_hint_cnt;

   always_comb begin
      w_hint_cnt = 6'd0;
      for (int i = 0; i < 32; i++)
         if (r_x[8*i +: 8] == TARGET[8*i +: 8]) w_hint_cnt = w_hint_cnt + 6'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       r_hint <= 6'd0;
      else if (r_state == ST_COMPARE)   r_hint <= w_hint_cnt;
      else if (w_state_nxt == ST_IDLE)  r_hint <= 6'd0;
   end

   assign hint_count = r_hint;
`else
   assign hint_count = 6'd0;
`endif

endmodule

// File: tb/tb_lockpick_vault.sv
// Directed bench for lockpick_vault: a win, three losses into lockout, stalls, resets mid-game, gapped input.
// Two instances: ROUNDS=3 with TARGET=hash(0), and ROUNDS=7 with TARGET=hash of a fixed key pair.
`timescale 1ns/1ps
module tb_lockpick_vault;

   localparam logic [2047:0] SBOX_T = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [2047:0] t;
      t = SBOX_T;
      return t[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [255:0] m_round(input logic [255:0] s);
      logic [63:0] a, b, c, d, f;
      logic [7:0]  y;
      {a, b, c, d} = s;
      f = ((b ^ d) + (a | c)) ^ {c[31:0], d[31:0]};
      for (int i = 0; i < 8; i++) begin
         y = f[8*i +: 8];
         f[8*i +: 8] = (y << 1) | (y >> 7);
      end
      f = (f << 13) | (f >> 51);
      for (int i = 0; i < 8; i++) f[8*i +: 8] = m_sbox(f[8*i +: 8]);
      a = a ^ f;
      b = (b << 33) | (b >> 31);
      c = c + a;
      d = ~d ^ b;
      a = (a << 16) | (a >> 48);
      return {a, b, c, d};
   endfunction

   function automatic logic [255:0] m_hash(input logic [255:0] x, input int rounds);
      logic [255:0] s;
      s = x;
      for (int r = 0; r < rounds; r++) s = m_round(s);
      return s;
   endfunction

   function automatic logic [5:0] m_hint(input logic [255:0] h, input logic [255:0] t);
      logic [5:0] n;
      n = 6'd0;
`ifdef LOCKPICK_HINT_EN
      for (int i = 0; i < 32; i++) if (h[8*i +: 8] == t[8*i +: 8]) n = n + 6'd1;
`else
      if (h === t && h !== t) n = 6'd1;
`endif
      return n;
   endfunction

   localparam logic [255:0] KA7 = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
   localparam logic [255:0] KB7 = 256'h5a5a3c3c_11223344_deadbeef_00ff00ff_a5a5a5a5_13579bdf_2468ace0_c0ffee00;
   localparam logic [255:0] T0  = m_hash(256'd0, 3);
   localparam logic [255:0] T7  = m_hash(KA7 ^ KB7, 7);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_s     [2];
   logic       in_valid_s  [2];
   logic [7:0] in_data_s   [2];
   logic       out_ready_s [2];
   wire        in_ready_s  [2];
   wire        out_valid_s [2];
   wire  [7:0] out_data_s  [2];
   wire  [1:0] status_s    [2];
   wire  [3:0] att_s       [2];
   wire        busy_s      [2];
   wire  [5:0] hint_s      [2];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lockpick_vault #(.KEY_BYTES(32), .ROUNDS(3), .MAX_ATTEMPTS(3), .COOLDOWN(16), .TARGET(T0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
      .in_ready(in_ready_s[0]), .out_valid(out_valid_s[0]), .out_data(out_data_s[0]),
      .out_ready(out_ready_s[0]), .status(status_s[0]), .attempts_left(att_s[0]), .busy(busy_s[0]),
      .hint_count(hint_s[0]));

   lockpick_vault #(.KEY_BYTES(32), .ROUNDS(7), .MAX_ATTEMPTS(3), .COOLDOWN(16), .TARGET(T7)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
      .in_ready(in_ready_s[1]), .out_valid(out_valid_s[1]), .out_data(out_data_s[1]),
      .out_ready(out_ready_s[1]), .status(status_s[1]), .attempts_left(att_s[1]), .busy(busy_s[1]),
      .hint_count(hint_s[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_reset(input int d);
      chk("rst_status", 64'(status_s[d]), 64'd0);
      chk("rst_attempts", 64'(att_s[d]), 64'd3);
      chk("rst_busy", 64'(busy_s[d]), 64'd0);
      chk("rst_in_ready", 64'(in_ready_s[d]), 64'd0);
      chk("rst_out_valid", 64'(out_valid_s[d]), 64'd0);
      chk("rst_out_data", 64'(out_data_s[d]), 64'd0);
      chk("rst_hint", 64'(hint_s[d]), 64'd0);
   endtask

   task automatic pulse_start(input int d);
      start_s[d] = 1'b1;
      @(negedge clk);
      start_s[d] = 1'b0;
   endtask

   task automatic send_byte(input int d, input logic [7:0] b);
      int guard;
      guard = 0;
      in_valid_s[d] = 1'b1;
      in_data_s[d]  = b;
      while (in_ready_s[d] !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready", 64'(in_ready_s[d]), 64'd1);
      @(negedge clk);
      in_valid_s[d] = 1'b0;
   endtask

   task automatic send_pair(input int d, input logic [255:0] ka, input logic [255:0] kb, input bit gapped);
      for (int i = 0; i < 64; i++) begin
         logic [7:0] b;
         b = (i < 32) ? ka[8*i +: 8] : kb[8*(i-32) +: 8];
         if (gapped) repeat ($urandom_range(0, 3)) @(negedge clk);
         send_byte(d, b);
      end
   endtask

   task automatic recv_msg(input int d, input logic [31:0] w, input int stall_at);
      for (int k = 0; k < 32; k++) begin
         logic [7:0] eb;
         eb = w[8*(k%4) +: 8];
         if (k == stall_at) begin
            out_ready_s[d] = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               chk("msg_stall", {55'd0, out_valid_s[d], out_data_s[d]}, {55'd0, 1'b1, eb});
            end
         end
         out_ready_s[d] = 1'b1;
         chk("msg_byte", {55'd0, out_valid_s[d], out_data_s[d]}, {55'd0, 1'b1, eb});
         @(negedge clk);
      end
      out_ready_s[d] = 1'b0;
      chk("msg_end_valid", 64'(out_valid_s[d]), 64'd0);
   endtask

   task automatic play(input int d, input logic [255:0] ka, input logic [255:0] kb, input bit gapped,
                       input int rounds, input logic [255:0] target, input logic [1:0] exp_st,
                       input logic [3:0] exp_att, input logic [31:0] word, input int stall_at);
      int cnt;
      send_pair(d, ka, kb, gapped);
      chk("busy_hash", 64'(busy_s[d]), 64'd1);
      cnt = 0;
      while (out_valid_s[d] !== 1'b1 && cnt < 64) begin
         @(negedge clk);
         cnt++;
      end
      chk("latency", 64'(cnt), 64'(rounds + 1));
      chk("status", 64'(status_s[d]), 64'(exp_st));
      chk("attempts", 64'(att_s[d]), 64'(exp_att));
      chk("hint", 64'(hint_s[d]), 64'(m_hint(m_hash(ka ^ kb, rounds), target)));
      recv_msg(d, word, stall_at);
   endtask

   function automatic logic [255:0] rep(input logic [7:0] b);
      return {32{b}};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0; in_valid_s[d] = 1'b0; in_data_s[d] = 8'h00; out_ready_s[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      rst_n = 1'b1;
      @(negedge clk);

      // Golden win: equal keys give X=0, TARGET is hash(0); stall 5 cycles mid-message.
      pulse_start(0);
      chk("start_busy", 64'(busy_s[0]), 64'd1);
      play(0, rep(8'hA5), rep(8'hA5), 1'b0, 3, T0, 2'b10, 4'd3, 32'hFACEFACE, 10);
      chk("win_idle_busy", 64'(busy_s[0]), 64'd0);
      chk("win_status_held", 64'(status_s[0]), 64'd2);
      pulse_start(0);
      chk("status_cleared", 64'(status_s[0]), 64'd0);

      // Three wrong pairs into lockout.
      play(0, rep(8'h11), KA7, 1'b0, 3, T0, 2'b01, 4'd2, 32'hBAD0BAD0, 40);
      chk("retry_in_ready", 64'(in_ready_s[0]), 64'd1);
      play(0, rep(8'h22), KB7, 1'b1, 3, T0, 2'b01, 4'd1, 32'hBAD0BAD0, 40);
      play(0, rep(8'h33), KA7, 1'b0, 3, T0, 2'b11, 4'd0, 32'hDEADDEAD, 3);
      chk("locked_busy", 64'(busy_s[0]), 64'd1);
      chk("locked_status", 64'(status_s[0]), 64'd3);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 3) start_s[0] = 1'b1;
         if (i == 4) start_s[0] = 1'b0;
      end
      chk("cooldown_busy15", 64'(busy_s[0]), 64'd1);
      chk("cooldown_in_ready", 64'(in_ready_s[0]), 64'd0);
      @(negedge clk);
      chk("cooldown_done_busy", 64'(busy_s[0]), 64'd0);
      chk("cooldown_attempts", 64'(att_s[0]), 64'd3);
      chk("cooldown_status", 64'(status_s[0]), 64'd0);
      chk("start_ignored", 64'(in_ready_s[0]), 64'd0);

      // Reset during LOAD_B of a second attempt.
      pulse_start(0);
      play(0, rep(8'h44), KB7, 1'b0, 3, T0, 2'b01, 4'd2, 32'hBAD0BAD0, 40);
      for (int i = 0; i < 37; i++) send_byte(0, 8'(i));
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset(0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset during OUTPUT.
      pulse_start(0);
      send_pair(0, rep(8'h55), KA7, 1'b0);
      cnt = 0;
      while (out_valid_s[0] !== 1'b1 && cnt < 64) begin
         @(negedge clk);
         cnt++;
      end
      chk("pre_rst_out_valid", 64'(out_valid_s[0]), 64'd1);
      out_ready_s[0] = 1'b1;
      repeat (4) @(negedge clk);
      out_ready_s[0] = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset(0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fresh game after reset, gapped input.
      pulse_start(0);
      chk("fresh_status", 64'(status_s[0]), 64'd0);
      play(0, rep(8'h3C), rep(8'h3C), 1'b1, 3, T0, 2'b10, 4'd3, 32'hFACEFACE, 40);

      // ROUNDS=7 instance, gapped distinct keys, TARGET is the model hash of their XOR.
      pulse_start(1);
      play(1, KA7, KB7, 1'b1, 7, T7, 2'b10, 4'd3, 32'hFACEFACE, 17);
      chk("r7_idle_busy", 64'(busy_s[1]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
